// File: rtl/psum_pkg.sv
// Shared types and default sizing for the psum collector.
// The state encoding is visible on the collector's debug port.
package psum_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_COL     = 10;
  localparam int DEF_BUFFER_SIZE = 512;
  localparam int DEF_FIFO_DEPTH  = 8;

  localparam int PSUM_W = 2 * DEF_DATA_WIDTH;
  localparam int ID_W   = $clog2(DEF_NUM_COL) + 1;
  localparam int AW     = $clog2(DEF_BUFFER_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } collector_state_e;

endpackage

// File: rtl/psum_collector_fifo.sv
// Synchronous FIFO with a registered storage read: a word pushed at edge t
// becomes visible at dout only after that edge, never combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects partial sums from the PE output lanes round-robin, buffers them and
// writes them as a linear {psum, lane id} stream into the GLB psum buffer.
module psum_collector
  import psum_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int  NUM_COL     = DEF_NUM_COL,
  parameter int  BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int  FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int PSUM_BITS   = 2 * DATA_WIDTH,
  localparam int ID_BITS     = $clog2(NUM_COL) + 1,
  localparam int ADDR_BITS   = $clog2(BUFFER_SIZE),
  localparam int CNT_BITS    = ADDR_BITS + 1,
  localparam int OUT_BITS    = PSUM_BITS + ID_BITS
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [CNT_BITS-1:0]          expected_cnt,
  input  logic [ADDR_BITS-1:0]         base_addr,
  input  logic [NUM_COL-1:0]           in_valid,
  input  logic [NUM_COL*PSUM_BITS-1:0] in_psum,
  output logic [NUM_COL-1:0]           in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_BITS-1:0]         out_addr,
  output logic [OUT_BITS-1:0]          out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         full,
  output collector_state_e             state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and data holds while valid & ~ready.

  collector_state_e state, state_next;

  logic [CNT_BITS-1:0]  exp_cnt;
  logic [CNT_BITS-1:0]  acc_cnt;
  logic [CNT_BITS-1:0]  wr_cnt;
  logic [ADDR_BITS-1:0] base_q;
  logic [ID_BITS-1:0]   rr_ptr;

  logic                 hi_found;
  logic                 lo_found;
  logic [ID_BITS-1:0]   hi_id;
  logic [ID_BITS-1:0]   lo_id;
  logic                 grant_found;
  logic [ID_BITS-1:0]   grant_id;
  logic [NUM_COL-1:0]   grant;
  logic [PSUM_BITS-1:0] grant_psum;

  logic                 can_accept;
  logic                 accept;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [OUT_BITS-1:0]  fifo_dout;

  // Lanes at or above the pointer win over lanes below it; within each half
  // the descending scan leaves the lowest valid index as the winner.
  always_comb begin
    hi_found   = 1'b0;
    lo_found   = 1'b0;
    hi_id      = '0;
    lo_id      = '0;
    grant      = '0;
    grant_psum = '0;
    for (int k = NUM_COL - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        if (ID_BITS'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = ID_BITS'(k);
        end else begin
          lo_found = 1'b1;
          lo_id    = ID_BITS'(k);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
    for (int k = 0; k < NUM_COL; k++) begin
      grant[k] = grant_found && (grant_id == ID_BITS'(k));
      if (grant[k]) grant_psum = in_psum[k*PSUM_BITS +: PSUM_BITS];
    end
  end

  assign can_accept = (state == COLLECT) && !fifo_full && (acc_cnt < exp_cnt);
  assign accept     = grant_found && can_accept;
  assign in_ready   = grant & {NUM_COL{can_accept}};

  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign out_addr   = base_q + wr_cnt[ADDR_BITS-1:0];
  assign out_data   = fifo_dout;
  assign full       = fifo_full;

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign state_dbg  = state;

  sync_fifo #(
    .WIDTH (OUT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rstn),
    .push  (accept),
    .din   ({grant_psum, grant_id}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (expected_cnt == '0) ? DONE : COLLECT;
      COLLECT: if (acc_cnt == exp_cnt) state_next = DRAIN;
      DRAIN:   if ((wr_cnt == exp_cnt) && fifo_empty) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= IDLE;
      exp_cnt <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      base_q  <= '0;
      rr_ptr  <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && start) begin
        exp_cnt <= expected_cnt;
        base_q  <= base_addr;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (accept) begin
          acc_cnt <= acc_cnt + 1'b1;
          rr_ptr  <= (grant_id == ID_BITS'(NUM_COL - 1)) ? '0 : grant_id + 1'b1;
        end
        if (pop) wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: vector table of collection runs checked cycle by
// cycle against a reference model and an expected-write queue.
module tb_psum_collector;
  import psum_pkg::*;

  localparam int NC = DEF_NUM_COL;
  localparam int FD = DEF_FIFO_DEPTH;
  localparam int OW = PSUM_W + ID_W;
  localparam int W  = AW + OW;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start;
  logic [AW:0]            expected_cnt;
  logic [AW-1:0]          base_addr;
  logic [NC-1:0]          in_valid;
  logic [NC*PSUM_W-1:0]   in_psum;
  logic [NC-1:0]          in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [AW-1:0]          out_addr;
  logic [OW-1:0]          out_data;
  logic                   busy;
  logic                   done;
  logic                   full;
  collector_state_e       state_dbg;

  psum_collector dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .expected_cnt (expected_cnt),
    .base_addr    (base_addr),
    .in_valid     (in_valid),
    .in_psum      (in_psum),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .full         (full),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard and reference model
  logic [W-1:0]     exp_q[$];
  int               errors = 0;
  int               checks = 0;
  collector_state_e m_state;
  int               m_acc, m_wr, m_exp, m_base, m_ptr;
  logic [NC-1:0]    lane_mask;
  logic [PSUM_W-1:0] lane_val [NC];
  int               lane_hits [NC];
  int               rdy_mode;
  bit               rand_data;
  int               writes_seen;
  int               last_addr;

  typedef struct {
    int            base;
    int            cnt;
    logic [NC-1:0] mask;
    int            rdy;
    bit            rnd;
    int            exp_writes;
    int            exp_last;
    int            hits;
  } vec_t;

  vec_t vecs [6];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One clock: drive at the falling edge, check what the next rising edge will take.
  task automatic tick();
    logic [NC-1:0]    exp_rdy;
    logic [W-1:0]     e;
    collector_state_e nstate;
    int               g;
    int               occ;
    for (int k = 0; k < NC; k++) in_psum[k*PSUM_W +: PSUM_W] = lane_val[k];
    in_valid = lane_mask;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    #1;
    if (rstn) begin
      m_state = IDLE;
      m_acc = 0; m_wr = 0; m_exp = 0; m_base = 0; m_ptr = 0;
      exp_q.delete();
    end else begin
      occ = exp_q.size();
      nstate = m_state;
      case (m_state)
        IDLE:    if (start) nstate = (expected_cnt == 0) ? DONE : COLLECT;
        COLLECT: if (m_acc == m_exp) nstate = DRAIN;
        DRAIN:   if (m_wr == m_exp && occ == 0) nstate = DONE;
        default: nstate = IDLE;
      endcase
      g = -1;
      for (int i = 0; i < NC; i++) begin
        int idx;
        idx = (m_ptr + i) % NC;
        if (g < 0 && in_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (m_state == COLLECT && occ < FD && m_acc < m_exp && g >= 0) exp_rdy[g] = 1'b1;
      check("busy", busy, m_state != IDLE);
      check("done", done, m_state == DONE);
      check("state", state_dbg, m_state);
      check("full", full, occ == FD);
      check("out_valid", out_valid, occ != 0);
      check("in_ready", in_ready, exp_rdy);
      if (occ != 0) begin
        e = exp_q[0];
        check("out_addr", out_addr, e[W-1 -: AW]);
        check("out_data", out_data, e[OW-1:0]);
        if (out_ready) begin
          e = exp_q.pop_front();
          m_wr++;
          writes_seen++;
          last_addr = int'(e[W-1 -: AW]);
        end
      end
      if (exp_rdy != '0) begin
        exp_q.push_back({AW'(m_base + m_acc), lane_val[g], ID_W'(g)});
        lane_hits[g]++;
        m_acc++;
        m_ptr = (g + 1) % NC;
        lane_val[g] = rand_data ? $urandom : lane_val[g] + 1'b1;
      end
      if (m_state == IDLE && start) begin
        m_exp = int'(expected_cnt);
        m_base = int'(base_addr);
        m_acc = 0;
        m_wr = 0;
      end
      m_state = nstate;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_state != IDLE && n < budget) begin
      tick();
      n++;
    end
    check("idle_after_run", busy, 1'b0);
  endtask

  task automatic launch(input int base, input int cnt, input logic [NC-1:0] mask,
                        input int rdy, input bit rnd);
    base_addr = AW'(base);
    expected_cnt = (AW+1)'(cnt);
    lane_mask = mask;
    rdy_mode = rdy;
    rand_data = rnd;
    writes_seen = 0;
    last_addr = -1;
    for (int k = 0; k < NC; k++) begin
      lane_val[k] = rnd ? $urandom : PSUM_W'(1);
      lane_hits[k] = 0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    launch(v.base, v.cnt, v.mask, v.rdy, v.rnd);
    wait_idle(400);
    lane_mask = '0;
    check("writes", writes_seen, v.exp_writes);
    if (v.exp_writes > 0) check("last_addr", last_addr, v.exp_last);
    if (v.hits > 0)
      for (int k = 0; k < NC; k++)
        if (v.mask[k]) check("lane_hits", lane_hits[k], v.hits);
  endtask

  initial begin
    vecs[0] = '{base: 0,   cnt: 0,  mask: 10'h000, rdy: 0, rnd: 0, exp_writes: 0,  exp_last: 0,   hits: 0};
    vecs[1] = '{base: 0,   cnt: 20, mask: 10'h3FF, rdy: 0, rnd: 1, exp_writes: 20, exp_last: 19,  hits: 2};
    vecs[2] = '{base: 10,  cnt: 4,  mask: 10'h008, rdy: 0, rnd: 0, exp_writes: 4,  exp_last: 13,  hits: 4};
    vecs[3] = '{base: 510, cnt: 4,  mask: 10'h020, rdy: 0, rnd: 1, exp_writes: 4,  exp_last: 1,   hits: 4};
    vecs[4] = '{base: 100, cnt: 30, mask: 10'h299, rdy: 1, rnd: 1, exp_writes: 30, exp_last: 129, hits: 6};
    vecs[5] = '{base: 500, cnt: 25, mask: 10'h3FF, rdy: 1, rnd: 1, exp_writes: 25, exp_last: 12,  hits: 0};

    rstn = 1'b1;
    start = 1'b0;
    expected_cnt = '0;
    base_addr = '0;
    in_valid = '0;
    in_psum = '0;
    out_ready = 1'b0;
    lane_mask = '0;
    rdy_mode = 0;
    rand_data = 1'b0;
    writes_seen = 0;
    last_addr = -1;
    for (int k = 0; k < NC; k++) begin
      lane_val[k] = '0;
      lane_hits[k] = 0;
    end
    @(negedge clk);
    repeat (3) tick();
    rstn = 1'b0;

    check("rst_in_ready", in_ready, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_addr", out_addr, '0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_full", full, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // backpressure: FIFO fills, then drains in order once the buffer accepts
    launch(40, 12, '1, 2, 1'b1);
    repeat (14) tick();
    check("bp_full", full, 1'b1);
    check("bp_in_ready", in_ready, '0);
    check("bp_no_writes", writes_seen, 0);
    rdy_mode = 0;
    wait_idle(200);
    lane_mask = '0;
    check("bp_writes", writes_seen, 12);
    check("bp_last_addr", last_addr, 51);

    // reset in COLLECT with three entries buffered
    launch(200, 10, '1, 2, 1'b1);
    for (int n = 0; n < 20 && exp_q.size() < 3; n++) tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    lane_mask = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", state_dbg, IDLE);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_full", full, 1'b0);
    tick();
    run_vec(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
